// File: rtl/alu_pkg.sv
// Shared definitions for the execute-stage output register: branch funct3 codes,
// NZCV flag bit positions, skid buffer state encoding and the branch condition helper.
package alu_pkg;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam int FLG_N = 3;
  localparam int FLG_Z = 2;
  localparam int FLG_C = 1;
  localparam int FLG_V = 0;

  typedef enum logic [1:0] {
    SKID_EMPTY = 2'd0,
    SKID_ONE   = 2'd1,
    SKID_TWO   = 2'd2
  } skid_state_e;

  // Flags come from a subtract, so C=1 means no borrow (a >= b unsigned).
  function automatic logic branch_cond(input logic [2:0] funct3, input logic [3:0] flags);
    logic res;
    res = 1'b0;
    case (funct3)
      F3_BEQ:  res = flags[FLG_Z];
      F3_BNE:  res = !flags[FLG_Z];
      F3_BLT:  res = flags[FLG_N] ^ flags[FLG_V];
      F3_BGE:  res = !(flags[FLG_N] ^ flags[FLG_V]);
      F3_BLTU: res = !flags[FLG_C];
      F3_BGEU: res = flags[FLG_C];
      default: res = 1'b0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/alu_flag_branch_stage_if.sv
// Upstream/downstream handshake bundle for alu_flag_branch_stage.
// Carries out_illegal only when BRANCH_ILLEGAL_CHK_EN is defined.
interface alu_flag_branch_stage_if
  import alu_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int TAG_W  = 5
);
  // valid/ready: a beat transfers on any rising edge where valid & ready are both 1;
  // once valid is raised the sender holds valid and payload stable until that edge.
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_sum;
  logic              in_n;
  logic              in_z;
  logic              in_c;
  logic              in_v;
  logic              in_is_branch;
  logic [2:0]        in_funct3;
  logic              in_flag_we;
  logic [TAG_W-1:0]  in_tag;

  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_result;
  logic              out_taken;
  logic [TAG_W-1:0]  out_tag;
  logic [3:0]        flags_q;
  skid_state_e       skid_state;
`ifdef BRANCH_ILLEGAL_CHK_EN
  logic              out_illegal;
`endif

  modport slave (
    input  in_valid, in_sum, in_n, in_z, in_c, in_v, in_is_branch, in_funct3,
           in_flag_we, in_tag, out_ready,
    output in_ready, out_valid, out_result, out_taken, out_tag, flags_q, skid_state
`ifdef BRANCH_ILLEGAL_CHK_EN
    , output out_illegal
`endif
  );

  modport master (
    output in_valid, in_sum, in_n, in_z, in_c, in_v, in_is_branch, in_funct3,
           in_flag_we, in_tag, out_ready,
    input  in_ready, out_valid, out_result, out_taken, out_tag, flags_q, skid_state
`ifdef BRANCH_ILLEGAL_CHK_EN
    , input out_illegal
`endif
  );

endinterface

// File: rtl/alu_skid_buf.sv
// Generic 2-entry valid/ready buffer with a registered in_ready; strict FIFO order,
// head entry held stable while the consumer stalls.
module alu_skid_buf
  import alu_pkg::*;
#(
  parameter int W = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  input  logic [W-1:0] in_data_i,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [W-1:0] out_data_o,
  output skid_state_e state_o
);

  skid_state_e  state_q, state_d;
  logic [W-1:0] head_q, head_d;
  logic [W-1:0] tail_q, tail_d;
  logic         in_ready_q;
  logic         accept;
  logic         drain;

  assign accept      = in_valid_i & in_ready_q;
  assign drain       = out_valid_o & out_ready_i;
  assign out_valid_o = (state_q != SKID_EMPTY);
  assign out_data_o  = head_q;
  assign in_ready_o  = in_ready_q;
  assign state_o     = state_q;

  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    case (state_q)
      SKID_EMPTY: begin
        if (accept) begin
          head_d  = in_data_i;
          state_d = SKID_ONE;
        end
      end
      SKID_ONE: begin
        // Accept with drain replaces the head directly, so there is no bubble.
        if (accept && drain) begin
          head_d = in_data_i;
        end else if (accept) begin
          tail_d  = in_data_i;
          state_d = SKID_TWO;
        end else if (drain) begin
          state_d = SKID_EMPTY;
        end
      end
      SKID_TWO: begin
        if (drain) begin
          head_d  = tail_q;
          state_d = SKID_ONE;
        end
      end
      default: state_d = SKID_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= SKID_EMPTY;
      head_q     <= '0;
      tail_q     <= '0;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      in_ready_q <= (state_d != SKID_TWO);
    end
  end

endmodule

// File: rtl/alu_flag_branch_stage.sv
// Execute-stage output register: resolves branches from adder NZCV flags, keeps the
// architectural flag register and buffers results. Option: BRANCH_ILLEGAL_CHK_EN.
module alu_flag_branch_stage
  import alu_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int TAG_W  = 5
) (
  input logic clk,
  input logic rst_n,
  alu_flag_branch_stage_if.slave bus
);

`ifdef BRANCH_ILLEGAL_CHK_EN
  localparam int ILL_W = 1;
`else
  localparam int ILL_W = 0;
`endif
  localparam int PAY_W = 1 + ILL_W + TAG_W + DATA_W;

  logic [3:0]       in_flags;
  logic             in_taken;
  logic             accept;
  logic [3:0]       flags_q, flags_d;
  logic [PAY_W-1:0] pay_in;
  logic [PAY_W-1:0] pay_out;

  assign in_flags = {bus.in_n, bus.in_z, bus.in_c, bus.in_v};
  assign in_taken = bus.in_is_branch & branch_cond(bus.in_funct3, in_flags);
  assign accept   = bus.in_valid & bus.in_ready;

`ifdef BRANCH_ILLEGAL_CHK_EN
  logic in_illegal;
  assign in_illegal = bus.in_is_branch & (bus.in_funct3[2:1] == 2'b01);
  assign pay_in     = {in_taken, in_illegal, bus.in_tag, bus.in_sum};
  assign bus.out_illegal = pay_out[DATA_W+TAG_W];
`else
  assign pay_in = {in_taken, bus.in_tag, bus.in_sum};
`endif

  assign bus.out_result = pay_out[DATA_W-1:0];
  assign bus.out_tag    = pay_out[DATA_W +: TAG_W];
  assign bus.out_taken  = pay_out[PAY_W-1];

  alu_skid_buf #(.W(PAY_W)) u_skid (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid_i  (bus.in_valid),
    .in_ready_o  (bus.in_ready),
    .in_data_i   (pay_in),
    .out_valid_o (bus.out_valid),
    .out_ready_i (bus.out_ready),
    .out_data_o  (pay_out),
    .state_o     (bus.skid_state)
  );

  // Flags follow accepted ops only; downstream stalls never delay the update.
  always_comb begin
    flags_d = flags_q;
    if (accept && bus.in_flag_we) flags_d = in_flags;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) flags_q <= 4'b0000;
    else        flags_q <= flags_d;
  end

  assign bus.flags_q = flags_q;

endmodule

// File: tb/tb_alu_flag_branch_stage.sv
// Self-checking bench for alu_flag_branch_stage: operand-level reference model plus
// directed branch, backpressure, throughput, flag and reset scenarios.
module tb_alu_flag_branch_stage;
  import alu_pkg::*;

  typedef struct packed {
    logic [7:0] result;
    logic       taken;
    logic       illegal;
    logic [4:0] tag;
  } exp_t;

  logic clk;
  logic rst_n;
  logic chk_en;
  logic rand_rdy;
  logic rand_val;
  logic out_man;
  int   checks;
  int   errors;
  int   drain_cnt;

  logic [7:0] cur_a, cur_b;
  logic       cur_sub;
  exp_t       exp_q[$];
  logic [3:0] exp_flags;
  logic [4:0] drained_q[$];

  alu_flag_branch_stage_if bus ();

  alu_flag_branch_stage dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  assign bus.out_ready = rand_rdy ? rand_val : out_man;

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Stimulus-side adder: produces sum and NZCV as the upstream unit would.
  function automatic logic [11:0] adder(input logic [7:0] a, input logic [7:0] b, input logic sub);
    logic [8:0] r;
    logic [7:0] bb;
    logic       v;
    bb = sub ? ~b : b;
    r  = {1'b0, a} + {1'b0, bb} + {8'b0, sub};
    v  = (a[7] == bb[7]) && (r[7] != a[7]);
    return {r[7], (r[7:0] == 8'h00), r[8], v, r[7:0]};
  endfunction

  // Reference decision straight from operand comparison.
  function automatic exp_t model_entry(input logic [7:0] a, input logic [7:0] b, input logic sub,
                                       input logic br, input logic [2:0] f3, input logic [4:0] tag);
    exp_t e;
    int   sa, sb;
    sa = $signed(a);
    sb = $signed(b);
    e.result  = sub ? a - b : a + b;
    e.tag     = tag;
    e.taken   = 1'b0;
    e.illegal = br && (f3 == 3'd2 || f3 == 3'd3);
    if (br) begin
      case (f3)
        3'd0: e.taken = (a == b);
        3'd1: e.taken = (a != b);
        3'd4: e.taken = (sa < sb);
        3'd5: e.taken = (sa >= sb);
        3'd6: e.taken = (a < b);
        3'd7: e.taken = (a >= b);
        default: e.taken = 1'b0;
      endcase
    end
    return e;
  endfunction

  // model update at the active edge, from bench-driven inputs only
  always @(posedge clk) begin : model_p
    bit acc, drn;
    if (!rst_n) begin
      exp_q.delete();
      exp_flags = 4'b0000;
    end else begin
      acc = bus.in_valid && (exp_q.size() < 2);
      drn = (exp_q.size() > 0) && bus.out_ready;
      if (drn) void'(exp_q.pop_front());
      if (acc) begin
        exp_q.push_back(model_entry(cur_a, cur_b, cur_sub, bus.in_is_branch, bus.in_funct3, bus.in_tag));
        if (bus.in_flag_we) exp_flags = {bus.in_n, bus.in_z, bus.in_c, bus.in_v};
      end
    end
  end

  // compare process: samples 1 time unit before each rising edge
  always @(negedge clk) begin
    #4;
    if (rand_rdy) rand_val = 1'($urandom_range(0, 1));
    if (chk_en) begin
      check("out_valid", {31'b0, bus.out_valid}, {31'b0, exp_q.size() > 0});
      check("in_ready", {31'b0, bus.in_ready}, {31'b0, exp_q.size() < 2});
      check("flags_q", {28'b0, bus.flags_q}, {28'b0, exp_flags});
      if (exp_q.size() > 0) begin
        check("out_result", {24'b0, bus.out_result}, {24'b0, exp_q[0].result});
        check("out_taken", {31'b0, bus.out_taken}, {31'b0, exp_q[0].taken});
        check("out_tag", {27'b0, bus.out_tag}, {27'b0, exp_q[0].tag});
`ifdef BRANCH_ILLEGAL_CHK_EN
        check("out_illegal", {31'b0, bus.out_illegal}, {31'b0, exp_q[0].illegal});
`endif
      end
      if (bus.out_valid && bus.out_ready) begin
        drain_cnt++;
        drained_q.push_back(bus.out_tag);
      end
    end
  end

  // driver tasks: called at a falling edge, return at a falling edge
  task automatic set_op(input logic [7:0] a, input logic [7:0] b, input logic sub, input logic br,
                        input logic [2:0] f3, input logic we, input logic [4:0] tag);
    logic [11:0] r;
    r = adder(a, b, sub);
    cur_a = a;
    cur_b = b;
    cur_sub = sub;
    bus.in_sum = r[7:0];
    bus.in_v = r[8];
    bus.in_c = r[9];
    bus.in_z = r[10];
    bus.in_n = r[11];
    bus.in_is_branch = br;
    bus.in_funct3 = f3;
    bus.in_flag_we = we;
    bus.in_tag = tag;
    bus.in_valid = 1'b1;
  endtask

  task automatic wait_accept();
    int budget;
    budget = 0;
    while (!bus.in_ready && budget < 200) begin
      @(negedge clk);
      budget++;
    end
    if (!bus.in_ready) begin
      errors++;
      $display("FAIL accept_timeout: in_ready stuck 0 for tag %0d", bus.in_tag);
      bus.in_valid = 1'b0;
    end
    @(negedge clk);
  endtask

  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic sub, input logic br,
                      input logic [2:0] f3, input logic we, input logic [4:0] tag);
    set_op(a, b, sub, br, f3, we, tag);
    wait_accept();
  endtask

  task automatic idle();
    bus.in_valid = 1'b0;
    bus.in_flag_we = 1'b0;
  endtask

  task automatic dir_branch(input string name, input logic [7:0] a, input logic [7:0] b,
                            input logic [2:0] f3, input logic exp_taken, input logic [7:0] exp_sum);
    send(a, b, 1'b1, 1'b1, f3, 1'b0, 5'd7);
    idle();
    check({name, "_valid"}, {31'b0, bus.out_valid}, 32'd1);
    check({name, "_taken"}, {31'b0, bus.out_taken}, {31'b0, exp_taken});
    check({name, "_sum"}, {24'b0, bus.out_result}, {24'b0, exp_sum});
    @(negedge clk);
  endtask

  initial begin
    int d0;
    checks = 0; errors = 0; drain_cnt = 0;
    chk_en = 1'b0; rand_rdy = 1'b0; rand_val = 1'b0; out_man = 1'b1;
    rst_n = 1'b0;
    cur_a = '0; cur_b = '0; cur_sub = 1'b0;
    set_op(8'd0, 8'd0, 1'b0, 1'b0, 3'd0, 1'b0, 5'd0);
    idle();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    chk_en = 1'b1;

    // reset state
    check("rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
    check("rst_in_ready", {31'b0, bus.in_ready}, 32'd1);
    check("rst_flags", {28'b0, bus.flags_q}, 32'd0);
    check("rst_result", {24'b0, bus.out_result}, 32'd0);
    check("rst_tag", {27'b0, bus.out_tag}, 32'd0);
    check("rst_taken", {31'b0, bus.out_taken}, 32'd0);

    // directed branch decisions
    dir_branch("blt_5_7", 8'd5, 8'd7, F3_BLT, 1'b1, 8'hFE);
    dir_branch("bge_5_7", 8'd5, 8'd7, F3_BGE, 1'b0, 8'hFE);
    dir_branch("bltu_5_7", 8'd5, 8'd7, F3_BLTU, 1'b1, 8'hFE);
    dir_branch("bgeu_80_1", 8'h80, 8'h01, F3_BGEU, 1'b1, 8'h7F);
    dir_branch("bge_7f_80", 8'h7F, 8'h80, F3_BGE, 1'b1, 8'hFF);
    dir_branch("beq_9_9", 8'd9, 8'd9, F3_BEQ, 1'b1, 8'h00);
    dir_branch("bne_9_9", 8'd9, 8'd9, F3_BNE, 1'b0, 8'h00);
    dir_branch("f3_010", 8'd9, 8'd9, 3'b010, 1'b0, 8'h00);

    // flag register
    send(8'd0, 8'd0, 1'b0, 1'b0, 3'd0, 1'b1, 5'd4);
    idle();
    check("flags_zero_we", {28'b0, bus.flags_q}, 32'h4);
    send(8'd3, 8'd1, 1'b0, 1'b0, 3'd0, 1'b0, 5'd5);
    idle();
    check("flags_hold_nowe", {28'b0, bus.flags_q}, 32'h4);
    repeat (2) @(negedge clk);

    // backpressure: tags 1,2 fill the buffer, tag 3 must be held
    out_man = 1'b0;
    send(8'd11, 8'd1, 1'b0, 1'b0, 3'd0, 1'b0, 5'd1);
    send(8'd22, 8'd2, 1'b0, 1'b0, 3'd0, 1'b0, 5'd2);
    set_op(8'd33, 8'd3, 1'b0, 1'b0, 3'd0, 1'b0, 5'd3);
    check("bp_in_ready_low", {31'b0, bus.in_ready}, 32'd0);
    repeat (3) @(negedge clk);
    check("bp_still_full", {31'b0, bus.in_ready}, 32'd0);
    check("bp_head_tag", {27'b0, bus.out_tag}, 32'd1);
    check("bp_head_result", {24'b0, bus.out_result}, 32'd12);
    drained_q.delete();
    out_man = 1'b1;
    wait_accept();
    idle();
    repeat (4) @(negedge clk);
    check("bp_drain_count", drained_q.size(), 32'd3);
    if (drained_q.size() == 3) begin
      check("bp_order0", {27'b0, drained_q[0]}, 32'd1);
      check("bp_order1", {27'b0, drained_q[1]}, 32'd2);
      check("bp_order2", {27'b0, drained_q[2]}, 32'd3);
    end

    // throughput: 16 back-to-back ops, 1-cycle latency
    d0 = drain_cnt;
    for (int i = 0; i < 16; i++) begin
      send(8'($urandom), 8'($urandom), 1'b1, 1'b1, 3'($urandom_range(0, 7)), 1'b0, 5'(i));
      check("tp_valid", {31'b0, bus.out_valid}, 32'd1);
      check("tp_tag", {27'b0, bus.out_tag}, 32'(i));
    end
    idle();
    repeat (3) @(negedge clk);
    check("tp_drains", drain_cnt - d0, 32'd16);

    // randomized traffic with random downstream stalls
    rand_rdy = 1'b1;
    for (int i = 0; i < 300; i++) begin
      logic sub;
      sub = 1'($urandom_range(0, 1));
      send(8'($urandom), 8'($urandom), sub, sub & 1'($urandom_range(0, 1)),
           3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 5'($urandom));
      if ($urandom_range(0, 3) == 0) begin
        idle();
        @(negedge clk);
      end
    end
    idle();
    rand_rdy = 1'b0;
    out_man = 1'b1;
    repeat (4) @(negedge clk);

    // reset while full, with an offer pending
    out_man = 1'b0;
    send(8'h80, 8'h01, 1'b1, 1'b0, 3'd0, 1'b1, 5'd9);
    send(8'd1, 8'd2, 1'b0, 1'b0, 3'd0, 1'b0, 5'd10);
    check("pre_rst_full", {31'b0, bus.in_ready}, 32'd0);
    set_op(8'd5, 8'd6, 1'b0, 1'b0, 3'd0, 1'b1, 5'd11);
    rst_n = 1'b0;
    @(negedge clk);
    check("rst2_out_valid", {31'b0, bus.out_valid}, 32'd0);
    check("rst2_in_ready", {31'b0, bus.in_ready}, 32'd1);
    check("rst2_flags", {28'b0, bus.flags_q}, 32'd0);
    idle();
    rst_n = 1'b1;
    out_man = 1'b1;
    @(negedge clk);
    check("post_rst_empty", {31'b0, bus.out_valid}, 32'd0);

`ifdef BRANCH_ILLEGAL_CHK_EN
    send(8'd4, 8'd4, 1'b1, 1'b1, 3'b010, 1'b0, 5'd12);
    idle();
    check("illegal_flag", {31'b0, bus.out_illegal}, 32'd1);
    check("illegal_taken", {31'b0, bus.out_taken}, 32'd0);
    @(negedge clk);
`endif

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL global_timeout: bench did not complete");
    $fatal(1);
  end

endmodule
